robo_controller: RTL and testbench
==================================

ROBO_CONTROLLER -- requirements
Module: robo_controller

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, idle cycles after every command before sensors are re-sampled (range 1-7).
REQ-002 Parameter REMOVE_TIMEOUT, default 12, maximum consecutive cycles remover may be held high (range 1-15).
REQ-003 Parameter MAX_MOVES, default 255, forward-move budget before FAULT (range 1-255).
REQ-004 clock  input  1  single system clock; all state changes on posedge clock.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-006 start  input  1  level; 1 allows leaving IDLE.
REQ-007 head  input  1  1 = wall or map edge directly ahead.
REQ-008 left  input  1  1 = wall or map edge to robot's left.
REQ-009 under  input  1  1 = robot on BLACK (goal) cell.
REQ-010 barrier  input  1  1 = barrier cell (any strength) directly ahead.
REQ-011 avancar  output  1  move-forward command.
REQ-012 girar  output  1  rotate 90 deg counter-clockwise (left) command.
REQ-013 remover  output  1  barrier-downgrade command.
REQ-014 moves  output  8  count of forward commands issued.
REQ-015 state  output  4  current FSM state code.
REQ-016 done  output  1  goal reached.
REQ-017 fault  output  1  timeout or move budget exhausted.

Function
REQ-018 Design SHALL implement left-hand wall following for the maze environment, which applies a command on the same clock edge that samples it.
REQ-019 States and codes: IDLE=0, SENSE=1, TURN_L=2, FWD=3, TURN_R=4, REMOVE=5, SETTLE=6, DONE=7, FAULT=8.
REQ-020 avancar, girar, remover, done, fault SHALL be decoded from registered state/counters only; no combinational input-to-output path.
REQ-021 At most one of avancar/girar/remover SHALL be 1 in any cycle.
REQ-022 IDLE: all commands 0; start=1 -> SENSE next cycle, else stay.
REQ-023 SENSE: no command; sensors sampled this cycle; priority: under=1 -> DONE; barrier=1 -> REMOVE; left=0 and turned_left=0 -> TURN_L; head=0 -> FWD; else TURN_R.
REQ-024 TURN_L: girar=1 for exactly 1 cycle; sets turned_left=1; -> SETTLE.
REQ-025 turned_left SHALL be cleared on entry to FWD, TURN_R or REMOVE, suppressing a second consecutive left turn (no spinning).
REQ-026 FWD: avancar=1 for exactly 1 cycle; moves increments by 1; -> FAULT if moves (post-increment) == MAX_MOVES, else SETTLE.
REQ-027 TURN_R: girar=1 for exactly 3 consecutive cycles (2-bit turn counter 0..2); -> SETTLE.
REQ-028 REMOVE: remover=1 each cycle while barrier=1; first cycle with barrier=0 -> SETTLE with remover=0 in that cycle.
REQ-029 REMOVE: if remover has been 1 for REMOVE_TIMEOUT consecutive cycles and barrier still 1 -> FAULT.
REQ-030 SETTLE: all commands 0 for SETTLE_CYCLES cycles (3-bit counter), then SENSE.
REQ-031 DONE: done=1, commands 0; held until reset regardless of inputs.
REQ-032 FAULT: fault=1, commands 0; held until reset regardless of inputs.
REQ-033 start dropping to 0 outside IDLE SHALL have no effect (run completes to DONE/FAULT).
REQ-034 moves SHALL never wrap; increments only in FWD.

Reset
REQ-035 reset=1 at a posedge SHALL force state=IDLE, moves=0, turned_left=0, all counters 0, all outputs 0 on the following cycle, overriding any state including mid TURN_R, REMOVE or SETTLE.
REQ-036 Outputs SHALL be 0 in every cycle while reset is held.

Verification
REQ-037 start=1, head=0, left=1, barrier=0, under=0, SETTLE_CYCLES=1 -> states 0,1,3,6,1,3...; avancar pulses every 3rd cycle; moves 1,2,3.
REQ-038 From SENSE, left=0, head=0 held -> TURN_L (girar 1 cycle), SETTLE, SENSE, FWD (not TURN_L), moves=1.
REQ-039 From SENSE, head=1, left=1 -> girar high exactly 3 consecutive cycles, then SETTLE; moves unchanged.
REQ-040 barrier=1 for 9 cycles then 0 -> remover high 9 cycles then SETTLE; barrier held 1 with REMOVE_TIMEOUT=12 -> 12 remover cycles then fault=1.
REQ-041 under=1 at SENSE -> done=1, state=7 held 20 cycles with toggling inputs; MAX_MOVES=4 open corridor -> fault=1 after 4th avancar, moves=4.
REQ-042 reset asserted during 2nd girar cycle of TURN_R -> next cycle state=0, girar=0, moves=0.

Source files
------------

// File: rtl/robo_controller.sv
// Left-hand wall-following maze controller: sense, turn, step, clear barriers, settle.
// Command outputs are decoded from the registered state only, so sensors never reach them combinationally.
module robo_controller #(
  parameter int SETTLE_CYCLES  = 1,
  parameter int REMOVE_TIMEOUT = 12,
  parameter int MAX_MOVES      = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       head,
  input  logic       left,
  input  logic       under,
  input  logic       barrier,
  output logic       avancar,
  output logic       girar,
  output logic       remover,
  output logic [7:0] moves,
  output logic [3:0] state,
  output logic       done,
  output logic       fault
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    SENSE  = 4'd1,
    TURN_L = 4'd2,
    FWD    = 4'd3,
    TURN_R = 4'd4,
    REMOVE = 4'd5,
    SETTLE = 4'd6,
    DONE   = 4'd7,
    FAULT  = 4'd8
  } state_t;

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);
  localparam logic [3:0] REMOVE_LAST = 4'(REMOVE_TIMEOUT - 1);
  localparam logic [7:0] MOVE_LIMIT  = 8'(MAX_MOVES);

  state_t     state_q;
  logic [7:0] moves_q;
  logic       turned_left_q;
  logic [1:0] turn_q;
  logic [2:0] settle_q;
  logic [3:0] remove_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      moves_q       <= 8'd0;
      turned_left_q <= 1'b0;
      turn_q        <= 2'd0;
      settle_q      <= 3'd0;
      remove_q      <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_q <= SENSE;
        end
        SENSE: begin
          if (under) begin
            state_q <= DONE;
          end else if (barrier) begin
            state_q       <= REMOVE;
            turned_left_q <= 1'b0;
            remove_q      <= 4'd0;
          end else if (!left && !turned_left_q) begin
            // Left turn is only allowed once before a forward step, so the robot cannot spin in place.
            state_q       <= TURN_L;
            turned_left_q <= 1'b1;
          end else if (!head) begin
            state_q       <= FWD;
            turned_left_q <= 1'b0;
          end else begin
            state_q       <= TURN_R;
            turned_left_q <= 1'b0;
            turn_q        <= 2'd0;
          end
        end
        TURN_L: begin
          state_q  <= SETTLE;
          settle_q <= 3'd0;
        end
        FWD: begin
          moves_q  <= moves_q + 8'd1;
          settle_q <= 3'd0;
          if (moves_q + 8'd1 == MOVE_LIMIT) state_q <= FAULT;
          else                              state_q <= SETTLE;
        end
        TURN_R: begin
          // Right turn is three consecutive left rotations.
          if (turn_q == 2'd2) begin
            state_q  <= SETTLE;
            settle_q <= 3'd0;
          end else begin
            turn_q <= turn_q + 2'd1;
          end
        end
        REMOVE: begin
          if (!barrier) begin
            state_q  <= SETTLE;
            settle_q <= 3'd0;
          end else if (remove_q == REMOVE_LAST) begin
            state_q <= FAULT;
          end else begin
            remove_q <= remove_q + 4'd1;
          end
        end
        SETTLE: begin
          if (settle_q == SETTLE_LAST) state_q <= SENSE;
          else                         settle_q <= settle_q + 3'd1;
        end
        DONE:    state_q <= DONE;
        FAULT:   state_q <= FAULT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avancar = (state_q == FWD);
  assign girar   = (state_q == TURN_L) || (state_q == TURN_R);
  assign remover = (state_q == REMOVE);
  assign done    = (state_q == DONE);
  assign fault   = (state_q == FAULT);
  assign moves   = moves_q;
  assign state   = state_q;

endmodule

// File: tb/tb_robo_controller.sv
// Bench for robo_controller: directed scenarios then random sensor traffic,
// compared against a schedule-based reference of the maze controller behaviour.
module tb_robo_controller;
  localparam int SC = 1;
  localparam int TO = 12;
  localparam int MM = 4;

  logic       clock = 1'b0;
  logic       reset, start, head, left, under, barrier;
  logic       avancar, girar, remover, done, fault;
  logic [7:0] moves;
  logic [3:0] state;

  always #5 clock = ~clock;

  robo_controller #(.SETTLE_CYCLES(SC), .REMOVE_TIMEOUT(TO), .MAX_MOVES(MM)) dut (
    .clock(clock), .reset(reset), .start(start), .head(head), .left(left),
    .under(under), .barrier(barrier), .avancar(avancar), .girar(girar),
    .remover(remover), .moves(moves), .state(state), .done(done), .fault(fault)
  );

  int checks = 0;
  int errors = 0;
  int m_cur = 0;
  int m_moves = 0;
  int m_rmcnt = 0;
  bit m_tl = 1'b0;
  int q[$];
  int av_seen, gi_seen, rm_seen;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_settle();
    for (int i = 0; i < SC; i++) q.push_back(6);
  endtask

  task automatic advance();
    if (q.size() > 0) m_cur = q.pop_front();
    else              m_cur = 1;
  endtask

  // Reference: each decision schedules the cycles it occupies; an empty schedule means sense again.
  task automatic model_next();
    if (reset) begin
      m_cur = 0; m_moves = 0; m_tl = 1'b0; m_rmcnt = 0; q.delete();
      return;
    end
    case (m_cur)
      0: if (start) m_cur = 1;
      1: begin
        if (under) m_cur = 7;
        else if (barrier) begin m_tl = 1'b0; m_rmcnt = 1; m_cur = 5; end
        else if (!left && !m_tl) begin m_tl = 1'b1; push_settle(); m_cur = 2; end
        else if (!head) begin m_tl = 1'b0; m_cur = 3; end
        else begin m_tl = 1'b0; q.push_back(4); q.push_back(4); push_settle(); m_cur = 4; end
      end
      3: begin
        m_moves++;
        if (m_moves == MM) m_cur = 8;
        else begin push_settle(); advance(); end
      end
      5: begin
        if (!barrier) begin push_settle(); advance(); end
        else if (m_rmcnt == TO) m_cur = 8;
        else m_rmcnt++;
      end
      7, 8: ;
      default: advance();
    endcase
  endtask

  task automatic tick();
    chk("state", 16'(state), 16'(m_cur));
    chk("cmds", 16'({avancar, girar, remover}),
        16'({(m_cur == 3), (m_cur == 2 || m_cur == 4), (m_cur == 5)}));
    chk("done_fault", 16'({done, fault}), 16'({(m_cur == 7), (m_cur == 8)}));
    chk("moves", 16'(moves), 16'(m_moves));
    chk("cmd_exclusive", 16'($countones({avancar, girar, remover}) <= 1), 16'd1);
    if (avancar === 1'b1) av_seen++;
    if (girar === 1'b1)   gi_seen++;
    if (remover === 1'b1) rm_seen++;
    model_next();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; head = 1'b0; left = 1'b1; under = 1'b0; barrier = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    av_seen = 0; gi_seen = 0; rm_seen = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; head = 1'b0; left = 1'b1; under = 1'b0; barrier = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);

    // Reset state and outputs held low during reset
    do_reset();
    chk("reset_state", 16'(state), 16'd0);
    chk("reset_moves", 16'(moves), 16'd0);

    // Open corridor with left wall: sense/forward/settle rhythm
    start = 1'b1; head = 1'b0; left = 1'b1;
    repeat (10) tick();
    chk("corridor_moves", 16'(moves), 16'd3);
    chk("corridor_avancar", 16'(av_seen), 16'd3);

    // Left opening: one left turn, then forward rather than a second left turn
    do_reset();
    start = 1'b1; head = 1'b0; left = 1'b0;
    repeat (6) tick();
    chk("turnl_moves", 16'(moves), 16'd1);
    chk("turnl_girar", 16'(gi_seen), 16'd1);

    // Dead end ahead with wall left: right turn of three rotations
    do_reset();
    start = 1'b1; head = 1'b1; left = 1'b1;
    repeat (6) tick();
    chk("turnr_girar", 16'(gi_seen), 16'd3);
    chk("turnr_state", 16'(state), 16'd1);
    chk("turnr_moves", 16'(moves), 16'd0);

    // Barrier high for 9 cycles from the sense cycle
    do_reset();
    start = 1'b1; barrier = 1'b1;
    repeat (10) tick();
    barrier = 1'b0;
    tick();
    chk("remove_cycles", 16'(rm_seen), 16'd9);
    chk("remove_settle", 16'(state), 16'd6);

    // Barrier never clears: timeout
    do_reset();
    start = 1'b1; barrier = 1'b1;
    repeat (16) tick();
    chk("remove_timeout_cycles", 16'(rm_seen), 16'd12);
    chk("remove_timeout_fault", 16'(fault), 16'd1);

    // Goal reached, held under toggling inputs
    do_reset();
    start = 1'b1; under = 1'b1;
    repeat (2) tick();
    repeat (20) begin
      start = 1'($urandom_range(0, 1)); head = 1'($urandom_range(0, 1));
      left = 1'($urandom_range(0, 1)); under = 1'($urandom_range(0, 1));
      barrier = 1'($urandom_range(0, 1));
      tick();
    end
    chk("done_held", 16'(done), 16'd1);
    chk("done_state", 16'(state), 16'd7);

    // Move budget exhausted in an open corridor
    do_reset();
    start = 1'b1; head = 1'b0; left = 1'b1;
    repeat (14) tick();
    chk("budget_fault", 16'(fault), 16'd1);
    chk("budget_moves", 16'(moves), 16'd4);
    chk("budget_avancar", 16'(av_seen), 16'd4);

    // Reset during the second rotation of a right turn, after one forward step
    do_reset();
    start = 1'b1; head = 1'b0; left = 1'b1;
    repeat (4) tick();
    head = 1'b1;
    repeat (2) tick();
    chk("mid_turnr_girar", 16'(girar), 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_turnr_state", 16'(state), 16'd0);
    chk("mid_turnr_girar_off", 16'(girar), 16'd0);
    chk("mid_turnr_moves", 16'(moves), 16'd0);

    // Random sensor traffic with occasional resets
    repeat (3000) begin
      reset   = ($urandom_range(0, 99) == 0);
      start   = ($urandom_range(0, 7) != 0);
      head    = 1'($urandom_range(0, 1));
      left    = 1'($urandom_range(0, 1));
      under   = ($urandom_range(0, 29) == 0);
      barrier = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
